vga_timing_gen: RTL and testbench

- Pixel-clock-domain VGA timing generator and output stage.
- Produces X_ADDR, Y_ADDR and VGA_DE for the downstream combinational RGB selector.
- Accepts that selector's 10-bit RGB back and drives the DAC pins with HS, VS and BLANK aligned to the pixel data.
- Issues a once-per-frame pulse so the SDRAM read ports can rewind their frame pointers before active video.

---
 rtl/vga_timing_gen.sv | 196 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-clock VGA timing generator and DAC output stage.
//
// The horizontal and vertical counters walk the raster in the order active,
// front porch, sync, back porch. From the counters the block produces the
// registered pixel address (X_ADDR/Y_ADDR) and data-enable (VGA_DE) for a
// downstream combinational RGB selector. It takes that selector's colour back,
// delays it together with the raw sync and DE by OUT_DLY clocks, and drives
// the DAC pins. A one-clock pulse at the first clock of vertical sync lets
// frame-buffer readers rewind before the next active frame.
//
// Ports
//   iCLK          pixel clock
//   iRST_N        asynchronous active-low reset (release must be synchronous
//                 to iCLK; the caller provides the release synchroniser)
//   iRed/iGreen/iBlue  10-bit colour from the selector, combinational on
//                 X_ADDR/Y_ADDR/VGA_DE
//   X_ADDR/Y_ADDR active column/row, 0 outside active video
//   VGA_DE        current position is active video
//   oFrame_Start  one-clock pulse per frame, first clock of vertical sync
//   oVGA_R/G/B    DAC colour, forced to 0 while blanked
//   oVGA_HS/VS    sync with programmable polarity
//   oVGA_BLANK_N  low outside active video
//   oVGA_SYNC_N   tied 0 (no sync-on-green)
//   oVGA_CLOCK    inverted pixel clock for the DAC latch
//
// OUT_DLY is legal in the range 1..4.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0,
    parameter int OUT_DLY = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    output logic [10:0] X_ADDR,
    output logic [10:0] Y_ADDR,
    output logic        VGA_DE,
    output logic        oFrame_Start,
    output logic [9:0]  oVGA_R,
    output logic [9:0]  oVGA_G,
    output logic [9:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_CLOCK
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_C  = 11'(H_ACT);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACT);
    localparam logic [10:0] HS_BEG   = 11'(H_ACT + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACT + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACT + V_FP + V_SYNC);
    localparam logic        H_POL_B  = (H_POL != 0);
    localparam logic        V_POL_B  = (V_POL != 0);

    // Everything that travels through the output delay line.
    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } pix_t;

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] x_addr_q, x_addr_d;
    logic [10:0] y_addr_q, y_addr_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic        hs_raw, vs_raw;
    pix_t        pix_now;
    pix_t        pix_pre;

    // ---- raster counters and next-state decode ------------------------------
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end
        // Decoding from next-state lets the registered outputs describe the
        // same position the counters hold in the same cycle.
        de_d     = (h_cnt_d < H_ACT_C) && (v_cnt_d < V_ACT_C);
        x_addr_d = de_d ? h_cnt_d : 11'd0;
        y_addr_d = de_d ? v_cnt_d : 11'd0;
        fs_d     = (h_cnt_d == 11'd0) && (v_cnt_d == VS_BEG);
    end

    // Reset parks the counters on the last clock of the frame so the first
    // edge after release lands on (0,0).
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_cnt_q  <= H_LAST;
            v_cnt_q  <= V_LAST;
            x_addr_q <= 11'd0;
            y_addr_q <= 11'd0;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            x_addr_q <= x_addr_d;
            y_addr_q <= y_addr_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
        end
    end

    assign X_ADDR       = x_addr_q;
    assign Y_ADDR       = y_addr_q;
    assign VGA_DE       = de_q;
    assign oFrame_Start = fs_q;

    // Raw sync describes the position held in the counters this cycle, the
    // same position VGA_DE and the returned colour refer to.
    assign hs_raw = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_raw = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    assign pix_now = '{r: iRed, g: iGreen, b: iBlue, hs: hs_raw, vs: vs_raw, de: de_q};

    // ---- output delay line (OUT_DLY-1 raw stages) ----------------------------
    // The final stage is the pin register below, so only OUT_DLY-1 raw stages
    // are needed here.
    generate
        if (OUT_DLY <= 1) begin : g_no_dly
            assign pix_pre = pix_now;
        end else begin : g_dly
            pix_t dly_q [OUT_DLY-1];

            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    for (int i = 0; i < OUT_DLY - 1; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= pix_now;
                    for (int i = 1; i < OUT_DLY - 1; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign pix_pre = dly_q[OUT_DLY-2];
        end
    endgenerate

    // ---- pin register -----------------------------------------------------------
    // Colour is gated by the delayed DE so nothing the selector produces
    // outside active video can reach the DAC.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R       <= 10'd0;
            oVGA_G       <= 10'd0;
            oVGA_B       <= 10'd0;
            oVGA_HS      <= ~H_POL_B;
            oVGA_VS      <= ~V_POL_B;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            oVGA_R       <= pix_pre.de ? pix_pre.r : 10'd0;
            oVGA_G       <= pix_pre.de ? pix_pre.g : 10'd0;
            oVGA_B       <= pix_pre.de ? pix_pre.b : 10'd0;
            oVGA_HS      <= pix_pre.hs ? H_POL_B : ~H_POL_B;
            oVGA_VS      <= pix_pre.vs ? V_POL_B : ~V_POL_B;
            oVGA_BLANK_N <= pix_pre.de;
        end
    end

    assign oVGA_SYNC_N = 1'b0;
    assign oVGA_CLOCK  = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one pixel clock:
//   A: default 640x480 timing, OUT_DLY = 1, constant red/blue, green = X_ADDR
//   B: default 640x480 timing, OUT_DLY = 3, red = X_ADDR, green = 3FF,
//      blue = Y_ADDR
//   C: 8x4 toy timing (14-clock line, 98-clock frame), H_POL = 1,
//      OUT_DLY = 2, red = X_ADDR, green = 3FF, blue = Y_ADDR
// Expected values are queued with the absolute cycle at which they must hold;
// a separate monitor compares every due entry on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing_gen;

    localparam int S_X  = 0;
    localparam int S_Y  = 1;
    localparam int S_DE = 2;
    localparam int S_FS = 3;
    localparam int S_R  = 4;
    localparam int S_G  = 5;
    localparam int S_B  = 6;
    localparam int S_HS = 7;
    localparam int S_VS = 8;
    localparam int S_BL = 9;
    localparam int S_SY = 10;

    // Toy timing used by instance C.
    localparam int C_HT  = 14;
    localparam int C_VT  = 7;
    localparam int C_HA  = 8;
    localparam int C_VA  = 4;
    localparam int C_HSB = 10;
    localparam int C_HSE = 13;
    localparam int C_VSB = 5;
    localparam int C_DLY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_ab_n;
    logic rst_c_n;

    logic [9:0]  a_ri, a_gi, a_bi, b_ri, b_gi, b_bi, c_ri, c_gi, c_bi;
    logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic        a_de, a_fs, b_de, b_fs, c_de, c_fs;
    logic [9:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic        a_hs, a_vs, a_bl, a_sy, a_ck;
    logic        b_hs, b_vs, b_bl, b_sy, b_ck;
    logic        c_hs, c_vs, c_bl, c_sy, c_ck;

    assign a_ri = 10'h155;
    assign a_gi = a_x[9:0];
    assign a_bi = 10'h0AA;
    assign b_ri = b_x[9:0];
    assign b_gi = 10'h3FF;
    assign b_bi = b_y[9:0];
    assign c_ri = c_x[9:0];
    assign c_gi = 10'h3FF;
    assign c_bi = c_y[9:0];

    vga_timing_gen #(.OUT_DLY(1)) u_a (
        .iCLK(clk), .iRST_N(rst_ab_n), .iRed(a_ri), .iGreen(a_gi), .iBlue(a_bi),
        .X_ADDR(a_x), .Y_ADDR(a_y), .VGA_DE(a_de), .oFrame_Start(a_fs),
        .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b), .oVGA_HS(a_hs), .oVGA_VS(a_vs),
        .oVGA_BLANK_N(a_bl), .oVGA_SYNC_N(a_sy), .oVGA_CLOCK(a_ck)
    );

    vga_timing_gen #(.OUT_DLY(3)) u_b (
        .iCLK(clk), .iRST_N(rst_ab_n), .iRed(b_ri), .iGreen(b_gi), .iBlue(b_bi),
        .X_ADDR(b_x), .Y_ADDR(b_y), .VGA_DE(b_de), .oFrame_Start(b_fs),
        .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b), .oVGA_HS(b_hs), .oVGA_VS(b_vs),
        .oVGA_BLANK_N(b_bl), .oVGA_SYNC_N(b_sy), .oVGA_CLOCK(b_ck)
    );

    vga_timing_gen #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(0), .OUT_DLY(C_DLY)
    ) u_c (
        .iCLK(clk), .iRST_N(rst_c_n), .iRed(c_ri), .iGreen(c_gi), .iBlue(c_bi),
        .X_ADDR(c_x), .Y_ADDR(c_y), .VGA_DE(c_de), .oFrame_Start(c_fs),
        .oVGA_R(c_r), .oVGA_G(c_g), .oVGA_B(c_b), .oVGA_HS(c_hs), .oVGA_VS(c_vs),
        .oVGA_BLANK_N(c_bl), .oVGA_SYNC_N(c_sy), .oVGA_CLOCK(c_ck)
    );

    // ---- scoreboard --------------------------------------------------------
    typedef struct {
        int    at;
        int    dut;
        int    sig;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic expect_at(input int at, input int d, input int s, input int e, input string nm);
        chk_t c;
        c.at   = at;
        c.dut  = d;
        c.sig  = s;
        c.exp  = e;
        c.name = nm;
        sb.push_back(c);
    endtask

    function automatic int pick(input int s, input logic [10:0] x, input logic [10:0] y,
                                input logic de, input logic fs, input logic [9:0] r,
                                input logic [9:0] g, input logic [9:0] b, input logic hs,
                                input logic vs, input logic bl, input logic sy);
        case (s)
            S_X:     return int'(x);
            S_Y:     return int'(y);
            S_DE:    return int'(de);
            S_FS:    return int'(fs);
            S_R:     return int'(r);
            S_G:     return int'(g);
            S_B:     return int'(b);
            S_HS:    return int'(hs);
            S_VS:    return int'(vs);
            S_BL:    return int'(bl);
            S_SY:    return int'(sy);
            default: return -1;
        endcase
    endfunction

    function automatic int get_sig(input int d, input int s);
        case (d)
            0:       return pick(s, a_x, a_y, a_de, a_fs, a_r, a_g, a_b, a_hs, a_vs, a_bl, a_sy);
            1:       return pick(s, b_x, b_y, b_de, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_bl, b_sy);
            default: return pick(s, c_x, c_y, c_de, c_fs, c_r, c_g, c_b, c_hs, c_vs, c_bl, c_sy);
        endcase
    endfunction

    // Monitor: every falling edge, compare all entries due this cycle.
    initial begin
        int act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    act = get_sig(sb[i].dut, sb[i].sig);
                    tests_run++;
                    if (act != sb[i].exp) begin
                        tests_failed++;
                        $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d",
                                 sb[i].name, sb[i].dut, cyc, act, sb[i].exp);
                    end
                    sb.delete(i);
                end else if (sb[i].at < cyc) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL %s dut%0d: check for cyc %0d never evaluated",
                             sb[i].name, sb[i].dut, sb[i].at);
                    sb.delete(i);
                end
            end
        end
    end

    // ---- stimulus helpers ---------------------------------------------------
    // Inputs change 2 ns after the rising edge, well clear of both edges.
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_reset_c(input int at);
        expect_at(at, 2, S_X,  0, "c_rst_x");
        expect_at(at, 2, S_Y,  0, "c_rst_y");
        expect_at(at, 2, S_DE, 0, "c_rst_de");
        expect_at(at, 2, S_FS, 0, "c_rst_fs");
        expect_at(at, 2, S_BL, 0, "c_rst_blank");
        expect_at(at, 2, S_R,  0, "c_rst_r");
        expect_at(at, 2, S_G,  0, "c_rst_g");
        expect_at(at, 2, S_B,  0, "c_rst_b");
        expect_at(at, 2, S_HS, 0, "c_rst_hs");
        expect_at(at, 2, S_VS, 1, "c_rst_vs");
    endtask

    // Expected behaviour of instance C at clocks n0..n1 after a release at
    // cycle base: clock n holds position index n-1 in raster order, and the
    // pins show what was presented C_DLY clocks earlier.
    task automatic push_model_c(input int base, input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            int h, v, de, m, hm, vm, dm;
            h  = (n - 1) % C_HT;
            v  = ((n - 1) / C_HT) % C_VT;
            de = (h < C_HA && v < C_VA) ? 1 : 0;
            expect_at(base + n, 2, S_DE, de, "c_de");
            expect_at(base + n, 2, S_X, (de != 0) ? h : 0, "c_x");
            expect_at(base + n, 2, S_Y, (de != 0) ? v : 0, "c_y");
            expect_at(base + n, 2, S_FS, (h == 0 && v == C_VSB) ? 1 : 0, "c_fs");
            m = n - C_DLY;
            if (m <= 0) begin
                expect_at(base + n, 2, S_BL, 0, "c_pin_blank");
                expect_at(base + n, 2, S_R,  0, "c_pin_r");
                expect_at(base + n, 2, S_G,  0, "c_pin_g");
                expect_at(base + n, 2, S_B,  0, "c_pin_b");
                expect_at(base + n, 2, S_HS, 0, "c_pin_hs");
                expect_at(base + n, 2, S_VS, 1, "c_pin_vs");
            end else begin
                hm = (m - 1) % C_HT;
                vm = ((m - 1) / C_HT) % C_VT;
                dm = (hm < C_HA && vm < C_VA) ? 1 : 0;
                expect_at(base + n, 2, S_BL, dm, "c_pin_blank");
                expect_at(base + n, 2, S_R,  (dm != 0) ? hm : 0, "c_pin_r");
                expect_at(base + n, 2, S_G,  (dm != 0) ? 1023 : 0, "c_pin_g");
                expect_at(base + n, 2, S_B,  (dm != 0) ? vm : 0, "c_pin_b");
                expect_at(base + n, 2, S_HS, (hm >= C_HSB && hm < C_HSE) ? 1 : 0, "c_pin_hs");
                expect_at(base + n, 2, S_VS, (vm == C_VSB) ? 0 : 1, "c_pin_vs");
            end
        end
    endtask

    // ---- directed sequence -------------------------------------------------
    initial begin
        int r1, r2, r3;
        rst_ab_n = 1'b0;
        rst_c_n  = 1'b0;
        tick(2);

        // Reset state, even with non-zero colour on the inputs.
        expect_at(cyc, 0, S_X,  0, "a_rst_x");
        expect_at(cyc, 0, S_Y,  0, "a_rst_y");
        expect_at(cyc, 0, S_DE, 0, "a_rst_de");
        expect_at(cyc, 0, S_FS, 0, "a_rst_fs");
        expect_at(cyc, 0, S_R,  0, "a_rst_r");
        expect_at(cyc, 0, S_BL, 0, "a_rst_blank");
        expect_at(cyc, 0, S_HS, 1, "a_rst_hs");
        expect_at(cyc, 0, S_VS, 1, "a_rst_vs");
        expect_at(cyc, 0, S_SY, 0, "a_rst_sync");
        expect_at(cyc, 1, S_G,  0, "b_rst_g");
        push_reset_c(cyc);
        tick(1);

        // Phase 1: default timing, instances A and B.
        r1 = cyc;
        rst_ab_n = 1'b1;
        expect_at(r1 + 1,    0, S_DE, 1,     "a_first_de");
        expect_at(r1 + 1,    0, S_X,  0,     "a_first_x");
        expect_at(r1 + 1,    0, S_Y,  0,     "a_first_y");
        expect_at(r1 + 2,    0, S_X,  1,     "a_x_step");
        expect_at(r1 + 640,  0, S_X,  639,   "a_last_x");
        expect_at(r1 + 640,  0, S_DE, 1,     "a_last_de");
        expect_at(r1 + 641,  0, S_DE, 0,     "a_fp_de");
        expect_at(r1 + 641,  0, S_X,  0,     "a_fp_x");
        expect_at(r1 + 800,  0, S_DE, 0,     "a_bp_de");
        expect_at(r1 + 801,  0, S_DE, 1,     "a_line2_de");
        expect_at(r1 + 801,  0, S_X,  0,     "a_line2_x");
        expect_at(r1 + 801,  0, S_Y,  1,     "a_line2_y");
        expect_at(r1 + 1601, 0, S_Y,  2,     "a_line3_y");
        expect_at(r1 + 1000, 0, S_FS, 0,     "a_no_fs");
        expect_at(r1 + 1,    0, S_BL, 0,     "a_pin_blank_first");
        expect_at(r1 + 2,    0, S_BL, 1,     "a_pin_blank_on");
        expect_at(r1 + 2,    0, S_R,  'h155, "a_pin_r");
        expect_at(r1 + 2,    0, S_G,  0,     "a_pin_g0");
        expect_at(r1 + 3,    0, S_G,  1,     "a_pin_g1");
        expect_at(r1 + 641,  0, S_G,  639,   "a_pin_g_last");
        expect_at(r1 + 641,  0, S_BL, 1,     "a_pin_blank_last");
        expect_at(r1 + 642,  0, S_BL, 0,     "a_pin_blank_off");
        expect_at(r1 + 642,  0, S_R,  0,     "a_pin_r_blanked");
        expect_at(r1 + 642,  0, S_G,  0,     "a_pin_g_blanked");
        expect_at(r1 + 801,  0, S_BL, 0,     "a_pin_blank_l2_pre");
        expect_at(r1 + 802,  0, S_BL, 1,     "a_pin_blank_l2");
        expect_at(r1 + 657,  0, S_HS, 1,     "a_hs_before");
        expect_at(r1 + 658,  0, S_HS, 0,     "a_hs_start");
        expect_at(r1 + 753,  0, S_HS, 0,     "a_hs_end");
        expect_at(r1 + 754,  0, S_HS, 1,     "a_hs_after");
        expect_at(r1 + 1457, 0, S_HS, 1,     "a_hs_l2_before");
        expect_at(r1 + 1458, 0, S_HS, 0,     "a_hs_l2_start");
        expect_at(r1 + 1000, 0, S_VS, 1,     "a_vs_idle");
        expect_at(r1 + 5,    0, S_SY, 0,     "a_sync_n");

        expect_at(r1 + 1,    1, S_DE, 1,     "b_first_de");
        expect_at(r1 + 3,    1, S_BL, 0,     "b_pin_blank_first");
        expect_at(r1 + 3,    1, S_R,  0,     "b_pin_r_first");
        expect_at(r1 + 4,    1, S_BL, 1,     "b_pin_blank_on");
        expect_at(r1 + 4,    1, S_R,  0,     "b_pin_r0");
        expect_at(r1 + 4,    1, S_G,  'h3FF, "b_pin_g");
        expect_at(r1 + 4,    1, S_B,  0,     "b_pin_b0");
        expect_at(r1 + 10,   1, S_R,  6,     "b_pin_r6");
        expect_at(r1 + 643,  1, S_R,  639,   "b_pin_r_last");
        expect_at(r1 + 643,  1, S_BL, 1,     "b_pin_blank_last");
        expect_at(r1 + 644,  1, S_BL, 0,     "b_pin_blank_off");
        expect_at(r1 + 644,  1, S_R,  0,     "b_pin_r_blanked");
        expect_at(r1 + 644,  1, S_G,  0,     "b_pin_g_blanked");
        expect_at(r1 + 644,  1, S_B,  0,     "b_pin_b_blanked");
        expect_at(r1 + 803,  1, S_BL, 0,     "b_pin_blank_l2_pre");
        expect_at(r1 + 803,  1, S_G,  0,     "b_pin_g_l2_pre");
        expect_at(r1 + 804,  1, S_BL, 1,     "b_pin_blank_l2");
        expect_at(r1 + 804,  1, S_R,  0,     "b_pin_r_l2");
        expect_at(r1 + 804,  1, S_B,  1,     "b_pin_b_l2");
        expect_at(r1 + 805,  1, S_R,  1,     "b_pin_r_l2_x1");
        expect_at(r1 + 659,  1, S_HS, 1,     "b_hs_before");
        expect_at(r1 + 660,  1, S_HS, 0,     "b_hs_start");
        expect_at(r1 + 755,  1, S_HS, 0,     "b_hs_end");
        expect_at(r1 + 756,  1, S_HS, 1,     "b_hs_after");
        tick(1700);

        // Phase 2: toy timing, three full frames plus a partial fourth.
        r2 = cyc;
        rst_c_n = 1'b1;
        push_model_c(r2, 1, 327);
        expect_at(r2 + 71,  2, S_FS, 1, "c_fs_frame1");
        expect_at(r2 + 169, 2, S_FS, 1, "c_fs_frame2");
        expect_at(r2 + 267, 2, S_FS, 1, "c_fs_frame3");
        tick(328);

        // Phase 3: reset in the middle of active video at P = (5,2).
        rst_c_n = 1'b0;
        push_reset_c(cyc);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            expect_at(cyc, 2, S_DE, 0, "c_hold_de");
            expect_at(cyc, 2, S_BL, 0, "c_hold_blank");
        end
        r3 = cyc;
        rst_c_n = 1'b1;
        push_model_c(r3, 1, 110);
        expect_at(r3 + 71, 2, S_FS, 1, "c_fs_after_reset");
        tick(112);

        tick(2);
        while (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s dut%0d: check for cyc %0d left pending",
                     sb[0].name, sb[0].dut, sb[0].at);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
